// File: rtl/uart_pkg.sv
// Shared UART receive definitions: FSM states, parity selectors, legal oversampling ratios.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } rx_state_t;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    localparam int PRESC_8  = 8;
    localparam int PRESC_16 = 16;
    localparam int PRESC_32 = 32;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Serial input, frame configuration and received-word outputs of the UART receiver.
// No backpressure: Data_Valid is a one-cycle strobe with no ready.
interface uart_rx_if #(
    parameter int DATA_WIDTH = 8,
    parameter int PRESC_W    = 6
);
    logic                  RX_In;
    logic [PRESC_W-1:0]    Prescale;
    logic                  Par_En;
    logic                  Par_Type;
    logic [DATA_WIDTH-1:0] P_Data;
    logic                  Data_Valid;
    logic                  Par_Err;
    logic                  Stp_Err;

    modport master (
        output RX_In, Prescale, Par_En, Par_Type,
        input  P_Data, Data_Valid, Par_Err, Stp_Err
    );

    modport slave (
        input  RX_In, Prescale, Par_En, Par_Type,
        output P_Data, Data_Valid, Par_Err, Stp_Err
    );
endinterface

// File: rtl/uart_rx_sampler.sv
// Bit-period counter with 3-point mid-bit sampling and majority vote; bit_done marks the last clock of each bit.
// Latency: bit_val is valid while bit_done is high; no backpressure.
module uart_rx_sampler #(
    parameter int PRESC_W = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               active,
    input  logic [PRESC_W-1:0] presc,
    input  logic               rx,
    output logic               bit_val,
    output logic               bit_done
);
    import uart_pkg::*;

    logic [PRESC_W-1:0] edge_cnt;
    logic [PRESC_W-1:0] half;
    logic [PRESC_W-1:0] last;
    logic [2:0]         smp;

    assign half     = presc >> 1;
    assign last     = presc - PRESC_W'(1);
    assign bit_done = active && (edge_cnt == last);
    assign bit_val  = maj3(smp[0], smp[1], smp[2]);

    // Counter wraps on its own terminal count, so an illegal ratio still yields a finite bit period.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            edge_cnt <= '0;
            smp      <= '1;
        end else begin
            if (!active || bit_done) edge_cnt <= '0;
            else                     edge_cnt <= edge_cnt + PRESC_W'(1);

            if (active) begin
                if (edge_cnt == half - PRESC_W'(1)) smp[0] <= rx;
                if (edge_cnt == half)               smp[1] <= rx;
                if (edge_cnt == half + PRESC_W'(1)) smp[2] <= rx;
            end
        end
    end
endmodule

// File: rtl/uart_rx.sv
// UART receiver: oversampled start detection, LSB-first data, optional parity, one stop bit, error flags.
// Latency: Data_Valid one cycle after the stop-bit commit edge; no backpressure, output is a strobe.
module uart_rx #(
    parameter int DATA_WIDTH = 8,
    parameter int PRESC_W    = 6
) (
    input  logic      clk,
    input  logic      rst,
    uart_rx_if.slave  bus
);
    import uart_pkg::*;

    localparam int CNT_W = $clog2(DATA_WIDTH + 1);

    rx_state_t             state;
    logic [PRESC_W-1:0]    presc_q;
    logic                  par_en_q;
    logic                  par_type_q;
    logic                  par_fail;
    logic [CNT_W-1:0]      bit_cnt;
    logic [DATA_WIDTH-1:0] shift;
    logic                  active;
    logic                  bit_val;
    logic                  bit_done;

    assign active = (state != IDLE);

    uart_rx_sampler #(.PRESC_W(PRESC_W)) u_sampler (
        .clk      (clk),
        .rst      (rst),
        .active   (active),
        .presc    (presc_q),
        .rx       (bus.RX_In),
        .bit_val  (bit_val),
        .bit_done (bit_done)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            presc_q        <= '0;
            par_en_q       <= 1'b0;
            par_type_q     <= 1'b0;
            par_fail       <= 1'b0;
            bit_cnt        <= '0;
            shift          <= '0;
            bus.P_Data     <= '0;
            bus.Data_Valid <= 1'b0;
            bus.Par_Err    <= 1'b0;
            bus.Stp_Err    <= 1'b0;
        end else begin
            bus.Data_Valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (!bus.RX_In) begin
                        state      <= START;
                        presc_q    <= bus.Prescale;
                        par_en_q   <= bus.Par_En;
                        par_type_q <= bus.Par_Type;
                    end
                end
                START: begin
                    if (bit_done) begin
                        if (bit_val) begin
                            state <= IDLE;
                        end else begin
                            state       <= DATA;
                            bit_cnt     <= '0;
                            par_fail    <= 1'b0;
                            bus.Par_Err <= 1'b0;
                            bus.Stp_Err <= 1'b0;
                        end
                    end
                end
                DATA: begin
                    if (bit_done) begin
                        shift <= {bit_val, shift[DATA_WIDTH-1:1]};
                        if (bit_cnt == CNT_W'(DATA_WIDTH - 1)) state <= par_en_q ? PARITY : STOP;
                        else                                  bit_cnt <= bit_cnt + CNT_W'(1);
                    end
                end
                PARITY: begin
                    if (bit_done) begin
                        par_fail <= (bit_val != ((^shift) ^ (par_type_q == PAR_ODD)));
                        state    <= STOP;
                    end
                end
                STOP: begin
                    if (bit_done) begin
                        if (bit_val && !par_fail) begin
                            bus.P_Data     <= shift;
                            bus.Data_Valid <= 1'b1;
                        end
                        bus.Stp_Err <= !bit_val;
                        bus.Par_Err <= par_fail;
                        // A start bit already on the line at this edge is taken now, keeping zero-gap frames on cadence.
                        if (!bus.RX_In) begin
                            state      <= START;
                            presc_q    <= bus.Prescale;
                            par_en_q   <= bus.Par_En;
                            par_type_q <= bus.Par_Type;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_rx.sv
// Directed UART receive bench: stimulus pushes expected words into a scoreboard, a negedge monitor pops on Data_Valid.
module tb_uart_rx;
    import uart_pkg::*;

    localparam int DW = 8;
    localparam int PW = 6;

    typedef struct {
        logic [DW-1:0] data;
        int            when;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   passes = 0;
    exp_t sb[$];
    exp_t mon_e;

    uart_rx_if #(.DATA_WIDTH(DW), .PRESC_W(PW)) bus ();

    uart_rx #(.DATA_WIDTH(DW), .PRESC_W(PW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    endfunction

    always @(negedge clk) begin
        if (bus.Data_Valid) begin
            chk("dv_expected", 32'(sb.size() > 0), 32'd1);
            if (sb.size() > 0) begin
                mon_e = sb.pop_front();
                chk("dv_data", 32'(bus.P_Data), 32'(mon_e.data));
                chk("dv_cycle", 32'(cyc), 32'(mon_e.when));
                chk("dv_flags", 32'({bus.Par_Err, bus.Stp_Err}), 32'd0);
            end
        end
    end

    // Each clock of a bit: the value set here is the one seen at the next rising edge.
    task automatic drive_bit(input logic b, input int p, input int noise_at);
        for (int j = 0; j < p; j++) begin
            bus.RX_In = (j == noise_at) ? ~b : b;
            @(posedge clk); #1;
        end
    endtask

    task automatic idle(input int n);
        bus.RX_In = 1'b1;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [DW-1:0] d, input int p, input logic pe, input logic pt,
                              input logic par_bit, input logic stop_bit, input int noise_bit,
                              input logic expect_ok, input logic chk_clr);
        int n;
        bus.Prescale = PW'(p);
        bus.Par_En   = pe;
        bus.Par_Type = pt;
        n = pe ? DW + 3 : DW + 2;
        // t0 is the next edge; Data_Valid is registered at edge t0 + p*n (cycle t0+p*n+1 counting from t0+1).
        if (expect_ok) sb.push_back('{d, cyc + 1 + p * n});
        drive_bit(1'b0, p, -1);
        bus.Prescale = (p == PRESC_8) ? PW'(PRESC_16) : PW'(PRESC_8);
        bus.Par_En   = ~pe;
        bus.Par_Type = ~pt;
        for (int i = 0; i < DW; i++) begin
            drive_bit(d[i], p, (i == noise_bit) ? p / 2 + 1 : -1);
            if (chk_clr && i == 0) chk("flags_clear_after_start", 32'({bus.Par_Err, bus.Stp_Err}), 32'd0);
        end
        if (pe) drive_bit(par_bit, p, -1);
        drive_bit(stop_bit, p, -1);
    endtask

    initial begin
        bus.RX_In    = 1'b1;
        bus.Prescale = PW'(PRESC_8);
        bus.Par_En   = 1'b0;
        bus.Par_Type = PAR_EVEN;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_p_data", 32'(bus.P_Data), 32'd0);
        chk("rst_dv", 32'(bus.Data_Valid), 32'd0);
        chk("rst_par_err", 32'(bus.Par_Err), 32'd0);
        chk("rst_stp_err", 32'(bus.Stp_Err), 32'd0);
        rst = 1'b0;
        idle(5);

        // Prescale 8, no parity, 0xA5
        send_frame(8'hA5, PRESC_8, 1'b0, PAR_EVEN, 1'b0, 1'b1, -1, 1'b1, 1'b0);
        idle(4);
        chk("a5_p_data", 32'(bus.P_Data), 32'hA5);
        chk("a5_flags", 32'({bus.Par_Err, bus.Stp_Err}), 32'd0);

        // Prescale 16, even parity, 0x3C carries parity bit 0
        send_frame(8'h3C, PRESC_16, 1'b1, PAR_EVEN, 1'b0, 1'b1, -1, 1'b1, 1'b0);
        idle(4);
        chk("3c_p_data", 32'(bus.P_Data), 32'h3C);
        chk("3c_flags", 32'({bus.Par_Err, bus.Stp_Err}), 32'd0);

        // Prescale 16, odd parity, 0x81 needs parity 1; send 0
        send_frame(8'h81, PRESC_16, 1'b1, PAR_ODD, 1'b0, 1'b1, -1, 1'b0, 1'b0);
        idle(4);
        chk("par_err_set", 32'(bus.Par_Err), 32'd1);
        chk("par_err_stp", 32'(bus.Stp_Err), 32'd0);
        chk("par_err_hold_data", 32'(bus.P_Data), 32'h3C);

        // Stop bit low on 0x55, then a good 0x0F clears the flag after its start bit
        send_frame(8'h55, PRESC_8, 1'b0, PAR_EVEN, 1'b0, 1'b0, -1, 1'b0, 1'b0);
        idle(4);
        chk("stp_err_set", 32'(bus.Stp_Err), 32'd1);
        chk("stp_err_par", 32'(bus.Par_Err), 32'd0);
        chk("stp_err_hold_data", 32'(bus.P_Data), 32'h3C);
        send_frame(8'h0F, PRESC_8, 1'b0, PAR_EVEN, 1'b0, 1'b1, -1, 1'b1, 1'b1);
        idle(4);
        chk("0f_p_data", 32'(bus.P_Data), 32'h0F);

        // Two-clock glitch is rejected at the start-bit vote
        bus.Prescale = PW'(PRESC_8);
        bus.Par_En   = 1'b0;
        bus.RX_In    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        idle(12);
        chk("glitch_idle", 32'(dut.state), 32'(IDLE));
        chk("glitch_flags", 32'({bus.Par_Err, bus.Stp_Err}), 32'd0);
        chk("glitch_p_data", 32'(bus.P_Data), 32'h0F);

        // Noise on the middle sample of data bit 2, odd parity 0x6B (parity bit 0)
        send_frame(8'h6B, PRESC_8, 1'b1, PAR_ODD, 1'b0, 1'b1, 2, 1'b1, 1'b0);
        idle(4);
        chk("noise_p_data", 32'(bus.P_Data), 32'h6B);

        // Back-to-back, zero idle gap: pulses 80 cycles apart
        send_frame(8'h12, PRESC_8, 1'b0, PAR_EVEN, 1'b0, 1'b1, -1, 1'b1, 1'b0);
        send_frame(8'h34, PRESC_8, 1'b0, PAR_EVEN, 1'b0, 1'b1, -1, 1'b1, 1'b0);
        idle(3);
        chk("b2b_p_data", 32'(bus.P_Data), 32'h34);

        // Reset part-way into a third frame
        bus.Prescale = PW'(PRESC_8);
        bus.Par_En   = 1'b0;
        drive_bit(1'b0, PRESC_8, -1);
        drive_bit(1'b0, PRESC_8, -1);
        drive_bit(1'b1, PRESC_8, -1);
        drive_bit(1'b1, PRESC_8, -1);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_p_data", 32'(bus.P_Data), 32'd0);
        chk("async_rst_dv", 32'(bus.Data_Valid), 32'd0);
        chk("async_rst_flags", 32'({bus.Par_Err, bus.Stp_Err}), 32'd0);
        chk("async_rst_state", 32'(dut.state), 32'(IDLE));
        @(posedge clk);
        #1;
        bus.RX_In = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        idle(4);

        // Recovery at Prescale 32, even parity, 0xC3 (parity bit 0)
        send_frame(8'hC3, PRESC_32, 1'b1, PAR_EVEN, 1'b0, 1'b1, -1, 1'b1, 1'b0);
        idle(10);
        chk("c3_p_data", 32'(bus.P_Data), 32'hC3);
        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
